riscuinho_decode_issue: RTL and testbench
=========================================

// Module: riscuinho_decode_issue
// PURPOSE
//  Decode/issue stage feeding the integer ALU. Accepts a fetched RV32I instruction and its PC,
//  reads rs1/rs2 from the register file, and builds the ALU command: E, 16-bit alu_op, A and B.
//  Output is one registered pipeline stage with valid/ready handshake, stall hold and flush.
//  Sits between fetch and execute. The ALU drives out = 0 for LUI/AUIPC/JAL/JALR codes, so this
//  block remaps those instructions to ADD.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; fixed at 32 for RV32I
//  PC_WIDTH    32  program-counter width; zero-extended onto alu_A when PC is an operand
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  rst          in   1   reset, asynchronous, active-high
//  flush        in   1   synchronous kill of the output register (branch/trap redirect)
//  in_valid     in   1   fetch presents in_instr/in_pc
//  in_ready     out  1   = !out_valid || out_ready (combinational)
//  in_instr     in   32  instruction word
//  in_pc        in   PC  instruction address
//  rs1_addr     out  5   = in_instr[19:15], combinational
//  rs2_addr     out  5   = in_instr[24:20], combinational
//  rs1_data     in   DW  register-file read data, same cycle as rs1_addr
//  rs2_data     in   DW  register-file read data, same cycle as rs2_addr
//  out_valid    out  1   issue slot holds a decoded instruction
//  out_ready    in   1   execute consumes the slot
//  alu_E        out  1   ALU enable
//  alu_op       out  16  {instr[30:25], funct3, opcode}; funct7 bit 31 dropped
//  alu_A/alu_B  out  DW  ALU operands
//  out_rs2      out  DW  rs2_data; store data / branch compare operand
//  out_cmp_a    out  DW  rs1_data; branch compare operand
//  out_link     out  PC  pc + 4
//  out_rd       out  5   destination register
//  out_rd_we    out  1   write-back enable; forced 0 when rd == 0
//  out_illegal  out  1   instruction is not legal RV32I
// BEHAVIOUR
//  - Reset: out_valid=0. All data outputs are 0: alu_E, alu_op, alu_A, alu_B, out_*, out_illegal.
//  - Accept happens when in_valid && in_ready. The decode is registered on that edge, so latency is 1 cycle.
//  - Stall: while out_valid && !out_ready, every output holds stable and in_ready=0.
//  - out_valid next = flush ? 0 : accept ? 1 : (out_ready ? 0 : out_valid).
//  - Flush beats a simultaneous accept: the instruction accepted in that cycle is dropped.
//  - alu_op for R-type and I-type shifts: the raw fields. Examples: SUB=8033, SRA=82B3, SRAI=8293.
//  - alu_op for every other type: funct7 part forced to 0. Examples: ADDI=0013, LW=0103, BNE=00E3.
//  - Operands:
//    - R-type: A=rs1, B=rs2.
//    - I-type ALU: A=rs1, B=sext(imm_i).
//    - I-type shifts: B=shamt.
//    - Loads: A=rs1, B=sext(imm_i).
//    - Stores: A=rs1, B=sext(imm_s).
//    - Branch: A=pc, B=sext(imm_b), alu_op keeps the branch encoding; the ALU adds.
//    - JAL: op=0033, A=pc, B=sext(imm_j).
//    - JALR: op=0033, A=rs1, B=sext(imm_i).
//    - LUI: op=0033, A=0, B=imm_u.
//    - AUIPC: op=0033, A=pc, B=imm_u.
//  - out_rd_we=1 for LUI, AUIPC, JAL, JALR, loads, I-type and R-type, when rd != 0. Stores and branches give 0.
//  - Illegal conditions:
//    - opcode is not one of the 9 RV32I types;
//    - R-type funct7 is not 0, or is 0100000 with funct3 other than 000/101;
//    - shift with instr[25]=1, or funct7 other than 0/0100000 (0100000 is legal only for SRAI);
//    - load funct3 is 011, 110 or 111;
//    - store funct3 > 010;
//    - branch funct3 is 010 or 011;
//    - JALR funct3 != 0.
//  - Illegal response: out_illegal=1, alu_E=0, out_rd_we=0, alu_op=0. The slot is still issued with
//    out_valid=1 so the trap unit sees it.
//  - Legal instruction: alu_E=1.
//  - No hazard detection or forwarding: upstream stalls in_valid on RAW hazards.
// TESTING
//  - Reset pulse with in_valid=1 -> out_valid=0 and all outputs 0 until the first edge after rst falls.
//  - ADDI x5,x1,-3 with rs1_data=10 -> next cycle: op=0013, A=10, B=FFFFFFFD, rd=5, we=1.
//  - SUB x3,x1,x2 held with out_ready=0 for 3 cycles -> op=8033 and outputs stable; in_ready=0;
//    the next instruction is accepted in the cycle out_ready=1.
//  - LUI x7,0x12345 -> op=0033, A=0, B=12345000.
//  - AUIPC at pc=100 with imm 1 -> A=100, B=1000.
//  - BEQ at pc=40 with offset -8 -> op=0063, A=40, B=FFFFFFF8, we=0.
//  - flush asserted in the same cycle as an accept -> out_valid=0 on the next cycle;
//    the instruction is never issued.
//  - Word 0x00000000 -> out_illegal=1, alu_E=0, we=0, out_valid=1.
//  - Shift encoding with instr[25]=1 -> out_illegal=1.

Source files
------------

// File: rtl/riscuinho_decode_issue.sv
// riscuinho_decode_issue: RV32I decode/issue stage that builds the ALU command
// behind one registered valid/ready slot; LUI/AUIPC/JAL/JALR are remapped to ADD.
module riscuinho_decode_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_E,
    output logic [15:0]           alu_op,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [DATA_WIDTH-1:0] out_rs2,
    output logic [DATA_WIDTH-1:0] out_cmp_a,
    output logic [PC_WIDTH-1:0]   out_link,
    output logic [4:0]            out_rd,
    output logic                  out_rd_we,
    output logic                  out_illegal
);
    logic [6:0]            w_opc, w_f7;
    logic [2:0]            w_f3;
    logic                  w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_aui, w_shift;
    logic                  w_known, w_illegal, w_accept, w_we;
    logic [15:0]           w_op;
    logic [DATA_WIDTH-1:0] w_pc_ext, w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_a, w_b;
    logic                  r_valid, r_e, r_we, r_ill;
    logic [15:0]           r_op;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_rs2, r_cmp_a;
    logic [PC_WIDTH-1:0]   r_link;
    logic [4:0]            r_rd;

    assign w_opc    = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign w_r      = w_opc == 7'b0110011;
    assign w_i      = w_opc == 7'b0010011;
    assign w_ld     = w_opc == 7'b0000011;
    assign w_st     = w_opc == 7'b0100011;
    assign w_br     = w_opc == 7'b1100011;
    assign w_jal    = w_opc == 7'b1101111;
    assign w_jalr   = w_opc == 7'b1100111;
    assign w_lui    = w_opc == 7'b0110111;
    assign w_aui    = w_opc == 7'b0010111;
    assign w_shift  = w_i && w_f3[1:0] == 2'b01;
    assign w_known  = w_r | w_i | w_ld | w_st | w_br | w_jal | w_jalr | w_lui | w_aui;

    // instr[25]=1 on a shift makes funct7 neither 0 nor 0100000, so it is covered here
    assign w_illegal = !w_known
        || (w_r && !(w_f7 == 7'd0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
        || (w_shift && !(w_f7 == 7'd0 || (w_f7 == 7'b0100000 && w_f3 == 3'b101)))
        || (w_ld && (w_f3 == 3'b011 || w_f3[2:1] == 2'b11))
        || (w_st && w_f3 > 3'b010)
        || (w_br && w_f3[2:1] == 2'b01)
        || (w_jalr && w_f3 != 3'b000);

    assign w_pc_ext = DATA_WIDTH'(in_pc);
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'd0};

    assign w_op = w_illegal ? 16'h0000
                : (w_jal | w_jalr | w_lui | w_aui) ? 16'h0033
                : (w_r | w_shift) ? {in_instr[30:25], w_f3, w_opc}
                : {6'd0, w_f3, w_opc};
    assign w_a  = (w_illegal | w_lui) ? '0 : (w_br | w_jal | w_aui) ? w_pc_ext : rs1_data;
    assign w_b  = w_illegal ? '0
                : w_r ? rs2_data
                : w_shift ? DATA_WIDTH'(in_instr[24:20])
                : w_st ? w_imm_s
                : w_br ? w_imm_b
                : w_jal ? w_imm_j
                : (w_lui | w_aui) ? w_imm_u
                : w_imm_i;
    assign w_we = !w_illegal && !w_st && !w_br && in_instr[11:7] != 5'd0;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_e     <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rs2   <= '0;
            r_cmp_a <= '0;
            r_link  <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_valid <= flush ? 1'b0 : w_accept ? 1'b1 : out_ready ? 1'b0 : r_valid;
            if (w_accept) begin
                r_e     <= !w_illegal;
                r_op    <= w_op;
                r_a     <= w_a;
                r_b     <= w_b;
                r_rs2   <= rs2_data;
                r_cmp_a <= rs1_data;
                r_link  <= in_pc + PC_WIDTH'(4);
                r_rd    <= in_instr[11:7];
                r_we    <= w_we;
                r_ill   <= w_illegal;
            end
        end
    end

    assign out_valid   = r_valid;
    assign alu_E       = r_e;
    assign alu_op      = r_op;
    assign alu_A       = r_a;
    assign alu_B       = r_b;
    assign out_rs2     = r_rs2;
    assign out_cmp_a   = r_cmp_a;
    assign out_link    = r_link;
    assign out_rd      = r_rd;
    assign out_rd_we   = r_we;
    assign out_illegal = r_ill;
endmodule

// File: tb/tb_riscuinho_decode_issue.sv
// tb_riscuinho_decode_issue: directed and random checks of the decode/issue slot
// against a behavioural decode model and a one-entry slot model.
module tb_riscuinho_decode_issue;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, alu_E, out_rd_we, out_illegal;
    logic [31:0] in_instr = '0, in_pc = '0, rs1_data, rs2_data;
    logic [31:0] alu_A, alu_B, out_rs2, out_cmp_a, out_link;
    logic [15:0] alu_op;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [31:0] regs [32];

    typedef struct packed {
        logic        ill;
        logic [15:0] op;
        logic [31:0] a, b, rs2, cmp_a, link;
        logic [4:0]  rd;
        logic        we, wr;
    } exp_t;

    exp_t m_out;
    logic m_valid = 1'b0;
    logic run = 1'b0;
    int   checks = 0, failures = 0;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    riscuinho_decode_issue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_E(alu_E), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B), .out_rs2(out_rs2),
        .out_cmp_a(out_cmp_a), .out_link(out_link), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] w, input logic [31:0] pc,
                                    input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [2:0]  f3 = w[14:12];
        logic [6:0]  f7 = w[31:25];
        logic [12:0] ob = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        logic [20:0] oj = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        logic [11:0] os = {w[31:25], w[11:7]};
        logic [31:0] imm_i = 32'($signed(w[31:20]));
        logic legal = 1'b1;
        logic raw = 1'b0;
        e = '0;
        e.rs2 = r2; e.cmp_a = r1; e.link = pc + 32'd4; e.rd = w[11:7];
        case (w[6:0])
            7'h33: begin legal = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); raw = 1; e.a = r1; e.b = r2; e.wr = 1; end
            7'h13: begin
                e.a = r1; e.wr = 1;
                if (f3 == 1 || f3 == 5) begin
                    legal = f7 == 0 || (f7 == 7'h20 && f3 == 5); raw = 1; e.b = {27'd0, w[24:20]};
                end else e.b = imm_i;
            end
            7'h03: begin legal = !(f3 == 3 || f3 == 6 || f3 == 7); e.a = r1; e.b = imm_i; e.wr = 1; end
            7'h23: begin legal = f3 <= 2; e.a = r1; e.b = 32'($signed(os)); end
            7'h63: begin legal = f3 != 2 && f3 != 3; e.a = pc; e.b = 32'($signed(ob)); end
            7'h6F: begin e.a = pc; e.b = 32'($signed(oj)); e.wr = 1; end
            7'h67: begin legal = f3 == 0; e.a = r1; e.b = imm_i; e.wr = 1; end
            7'h37: begin e.a = 0; e.b = {w[31:12], 12'd0}; e.wr = 1; end
            7'h17: begin e.a = pc; e.b = {w[31:12], 12'd0}; e.wr = 1; end
            default: legal = 1'b0;
        endcase
        if (w[6:0] inside {7'h6F, 7'h67, 7'h37, 7'h17}) e.op = 16'h0033;
        else e.op = raw ? {w[30:25], f3, w[6:0]} : {6'd0, f3, w[6:0]};
        e.ill = !legal;
        if (!legal) begin e.op = 0; e.wr = 0; end
        e.we = legal && e.wr && w[11:7] != 0;
        return e;
    endfunction

    always @(posedge clk) if (run) begin
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_out.ill});
            chk("alu_E", {31'd0, alu_E}, {31'd0, !m_out.ill});
            chk("alu_op", {16'd0, alu_op}, {16'd0, m_out.op});
            chk("rd_we", {31'd0, out_rd_we}, {31'd0, m_out.we});
            chk("out_rs2", out_rs2, m_out.rs2);
            chk("out_cmp_a", out_cmp_a, m_out.cmp_a);
            chk("out_link", out_link, m_out.link);
            if (!m_out.ill) begin
                chk("alu_A", alu_A, m_out.a);
                chk("alu_B", alu_B, m_out.b);
            end
            if (m_out.wr) chk("out_rd", {27'd0, out_rd}, {27'd0, m_out.rd});
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic acc;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || ordy});
        chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, ins[19:15]});
        chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, ins[24:20]});
        acc = v && (!m_valid || ordy);
        if (acc) m_out = decode(ins, pc, regs[ins[19:15]], regs[ins[24:20]]);
        m_valid = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : m_valid;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 10);
        if (k == 10) return w;
        w[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    localparam logic [31:0] ADDI = 32'hFFD08293, SUB = 32'h402081B3, LUI = 32'h123453B7;
    localparam logic [31:0] AUIPC = 32'h00001097, BEQ = 32'hFE208CE3, SLLI_BAD = 32'h02009093;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 0; regs[1] = 10; regs[2] = 3;
        in_valid = 1'b1; in_instr = ADDI; out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_data", alu_A | alu_B | out_rs2 | out_cmp_a | out_link | {16'd0, alu_op}, 32'd0);
            chk("reset_flags", {27'd0, out_rd, alu_E, out_rd_we, out_illegal}, 32'd0);
        end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        run = 1'b1;

        step(1, ADDI, 32'h0, 1, 0);
        chk("addi_op", {16'd0, alu_op}, 32'h0013);
        chk("addi_A", alu_A, 32'd10);
        chk("addi_B", alu_B, 32'hFFFFFFFD);
        chk("addi_rd_we", {26'd0, out_rd, out_rd_we}, {26'd0, 5'd5, 1'b1});

        step(1, SUB, 32'h4, 1, 0);
        repeat (3) begin
            step(1, LUI, 32'h8, 0, 0);
            chk("stall_op", {16'd0, alu_op}, 32'h8033);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        step(1, ADDI, 32'hC, 1, 0);
        chk("after_stall_op", {16'd0, alu_op}, 32'h0013);

        step(1, LUI, 32'h10, 1, 0);
        chk("lui", {alu_op, 16'd0} ^ alu_A ^ alu_B, 32'h00330000 ^ 32'h12345000);
        step(1, AUIPC, 32'h100, 1, 0);
        chk("auipc_A", alu_A, 32'h100);
        chk("auipc_B", alu_B, 32'h1000);
        step(1, BEQ, 32'h40, 1, 0);
        chk("beq_op", {16'd0, alu_op}, 32'h0063);
        chk("beq_A", alu_A, 32'h40);
        chk("beq_B", alu_B, 32'hFFFFFFF8);
        chk("beq_we", {31'd0, out_rd_we}, 32'd0);

        step(1, LUI, 32'h44, 1, 1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        step(0, LUI, 32'h48, 1, 0);
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        step(1, 32'h0, 32'h50, 1, 0);
        chk("zero_word", {27'd0, out_valid, out_illegal, alu_E, out_rd_we, 1'b0}, 32'b11000);
        step(1, SLLI_BAD, 32'h54, 1, 0);
        chk("shift_bit25", {31'd0, out_illegal}, 32'd1);

        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, 2'b00} >> 2 << 2,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        step(0, 32'h0, 32'h0, 1, 0);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
